// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: data width, operation codes,
// FSM state encoding and the first-difference helper.
package alu_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_COMP  = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_XOR   = 5'd3;
   localparam logic [4:0] OP_SHLL  = 5'd4;
   localparam logic [4:0] OP_SHRL  = 5'd5;
   localparam logic [4:0] OP_SHLLV = 5'd6;
   localparam logic [4:0] OP_SHRLV = 5'd7;
   localparam logic [4:0] OP_SHRA  = 5'd8;
   localparam logic [4:0] OP_SHRAV = 5'd9;
   localparam logic [4:0] OP_B     = 5'd10;
   localparam logic [4:0] OP_BLTZ  = 5'd11;
   localparam logic [4:0] OP_BNZ   = 5'd12;
   localparam logic [4:0] OP_BZ    = 5'd13;
   localparam logic [4:0] OP_BCY   = 5'd14;
   localparam logic [4:0] OP_BNCY  = 5'd15;
   localparam logic [4:0] OP_DIFF  = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Index of the lowest differing bit, or DATA_W when the operands match.
   function automatic logic [DATA_W-1:0] first_diff(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] r;
      logic              found;
      x     = a ^ b;
      r     = DATA_W;
      found = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (x[i] && !found) begin
            r     = i;
            found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between a requester and the ALU execution unit.
interface alu_exec_unit_if;

   logic                         start;
   logic [4:0]                   alu_ctrl;
   logic [alu_pkg::DATA_W-1:0]   op_a;
   logic [alu_pkg::DATA_W-1:0]   op_b;
   logic [4:0]                   shamt;
   logic                         busy;
   logic                         done;
   logic [alu_pkg::DATA_W-1:0]   result;
   logic                         carry_flag;
   logic                         zero_flag;
   logic                         sign_flag;
   logic                         branch_taken;
   logic                         illegal;

   modport master (
      output start, alu_ctrl, op_a, op_b, shamt,
      input  busy, done, result, carry_flag, zero_flag, sign_flag, branch_taken, illegal
   );

   modport slave (
      input  start, alu_ctrl, op_a, op_b, shamt,
      output busy, done, result, carry_flag, zero_flag, sign_flag, branch_taken, illegal
   );

endinterface

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter; done flags the cycle whose shift is the last one.
module alu_shifter
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              dir_left,
   input  logic              arith,
   input  logic [4:0]        amount,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] data_next,
   output logic              done
);

   logic [DATA_W-1:0] data_q;
   logic [4:0]        count_q;

   always_comb begin
      if (dir_left) data_next = {data_q[DATA_W-2:0], 1'b0};
      else          data_next = {arith & data_q[DATA_W-1], data_q[DATA_W-1:1]};
   end

   assign done = (count_q == 5'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         count_q <= '0;
      end else if (load) begin
         data_q  <= data;
         count_q <= amount;
      end else if (count_q != '0) begin
         data_q  <= data_next;
         count_q <= count_q - 5'd1;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: latches a request, executes (iterating for shifts) and
// presents result, flags and branch decision with a one-cycle done pulse.
module alu_exec_unit
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   alu_exec_unit_if.slave  bus
);

   state_t            state_q, state_d;
   logic [4:0]        ctrl_q, shamt_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] result_q;
   logic              carry_q, zero_q, sign_q, branch_q, illegal_q;

   logic              is_shift, dir_left, arith;
   logic [4:0]        sh_amount;
   logic [DATA_W-1:0] sh_next;
   logic              sh_done;
   logic              accept, capture;

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] res_d;
   logic              carry_d, upd_zs, take, bad;

   assign is_shift  = (ctrl_q >= OP_SHLL) && (ctrl_q <= OP_SHRAV);
   assign dir_left  = (ctrl_q == OP_SHLL) || (ctrl_q == OP_SHLLV);
   assign arith     = (ctrl_q == OP_SHRA) || (ctrl_q == OP_SHRAV);
   assign sh_amount = ((ctrl_q == OP_SHLL) || (ctrl_q == OP_SHRL) || (ctrl_q == OP_SHRA))
                      ? shamt_q : b_q[4:0];
   assign accept    = (state_q == ST_IDLE) && bus.start;
   assign capture   = (state_q != ST_DONE) && (state_d == ST_DONE);

   alu_shifter u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == ST_EXEC),
      .dir_left  (dir_left),
      .arith     (arith),
      .amount    (sh_amount),
      .data      (a_q),
      .data_next (sh_next),
      .done      (sh_done)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_EXEC;
         ST_EXEC:  state_d = (is_shift && sh_amount != '0) ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (sh_done) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != ST_IDLE);
      bus.done = (state_q == ST_DONE);
   end

   // A zero-amount shift leaves EXEC directly, so its result is simply op_a.
   always_comb begin
      sum     = '0;
      res_d   = '0;
      carry_d = carry_q;
      upd_zs  = 1'b0;
      take    = 1'b0;
      bad     = 1'b0;
      if (state_q == ST_SHIFT) begin
         res_d  = sh_next;
         upd_zs = 1'b1;
      end else begin
         case (ctrl_q)
            OP_ADD: begin
               sum     = {1'b0, a_q} + {1'b0, b_q};
               res_d   = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
               upd_zs  = 1'b1;
            end
            OP_COMP: begin
               sum     = {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
               res_d   = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
               upd_zs  = 1'b1;
            end
            OP_AND:  begin res_d = a_q & b_q; upd_zs = 1'b1; end
            OP_XOR:  begin res_d = a_q ^ b_q; upd_zs = 1'b1; end
            OP_SHLL, OP_SHRL, OP_SHLLV, OP_SHRLV, OP_SHRA, OP_SHRAV: begin
               res_d  = a_q;
               upd_zs = 1'b1;
            end
            OP_DIFF: begin res_d = first_diff(a_q, b_q); upd_zs = 1'b1; end
            OP_B:    begin res_d = b_q; take = 1'b1; end
            OP_BLTZ: begin res_d = b_q; take = a_q[DATA_W-1]; end
            OP_BNZ:  begin res_d = b_q; take = (a_q != '0); end
            OP_BZ:   begin res_d = b_q; take = (a_q == '0); end
            OP_BCY:  begin res_d = b_q; take = carry_q; end
            OP_BNCY: begin res_d = b_q; take = !carry_q; end
            default: bad = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         shamt_q   <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         sign_q    <= 1'b0;
         branch_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         branch_q  <= 1'b0;
         illegal_q <= 1'b0;
         if (accept) begin
            ctrl_q  <= bus.alu_ctrl;
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            shamt_q <= bus.shamt;
         end
         if (capture) begin
            result_q  <= res_d;
            carry_q   <= carry_d;
            branch_q  <= take;
            illegal_q <= bad;
            if (upd_zs) begin
               zero_q <= (res_d == '0);
               sign_q <= res_d[DATA_W-1];
            end
         end
      end
   end

   assign bus.result       = result_q;
   assign bus.carry_flag   = carry_q;
   assign bus.zero_flag    = zero_q;
   assign bus.sign_flag    = sign_q;
   assign bus.branch_taken = branch_q;
   assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; observed word is {result, carry, zero, sign, branch_taken, illegal}.
module tb_alu_exec_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   alu_exec_unit_if bus ();

   alu_exec_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [36:0] outs();
      return {bus.result, bus.carry_flag, bus.zero_flag, bus.sign_flag, bus.branch_taken, bus.illegal};
   endfunction

   // Issues one request and waits for done; lat counts cycles after accept.
   task automatic run_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int lat, output logic busy_ok);
      @(negedge clk);
      bus.start = 1'b1; bus.alu_ctrl = ctrl; bus.op_a = a; bus.op_b = b; bus.shamt = sh;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      busy_ok = bus.busy;
      while (bus.done !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
         busy_ok &= bus.busy;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.alu_ctrl = '0; bus.op_a = '0; bus.op_b = '0; bus.shamt = '0;
      repeat (3) @(negedge clk);
      total++;
      if (outs() !== 37'h0) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs(), 37'h0); end
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {bus.busy, bus.done}); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat; logic bok;
      run_op(5'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, bok);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
      total++;
      if (bok !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", bok); end
      total++;
      if (outs() !== {32'h0, 5'b11000}) begin bad++; $display("FAIL add_outs got=%h exp=%h", outs(), {32'h0, 5'b11000}); end
      @(negedge clk);
      total++;
      if ({bus.done, bus.busy} !== 2'b00) begin bad++; $display("FAIL add_done_pulse got=%b exp=00", {bus.done, bus.busy}); end
   endtask

   task automatic test_shra();
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_ctrl = 5'd8; bus.op_a = 32'h8000_0000; bus.op_b = '0; bus.shamt = 5'd31;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
         bus.start = (lat == 4 || lat == 20);
         bus.alu_ctrl = 5'd0; bus.op_a = 32'h1; bus.op_b = 32'h1; bus.shamt = 5'd0;
      end
      total++;
      if (lat !== 33) begin bad++; $display("FAIL shra_latency got=%0d exp=33", lat); end
      total++;
      if (outs() !== {32'hFFFF_FFFF, 5'b10100}) begin bad++; $display("FAIL shra_outs got=%h exp=%h", outs(), {32'hFFFF_FFFF, 5'b10100}); end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL start_in_done got=%b exp=00", {bus.busy, bus.done}); end
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_in_done_late got=%b exp=0", bus.busy); end
   endtask

   task automatic test_comp_bcy();
      logic [4:0]  ctrl [5] = '{5'd1, 5'd14, 5'd1, 5'd14, 5'd15};
      logic [31:0] opb  [5] = '{32'h0, 32'h40, 32'h5, 32'h80, 32'h84};
      logic [36:0] expv [5] = '{{32'h0, 5'b11000}, {32'h40, 5'b11010}, {32'hFFFF_FFFB, 5'b00100},
                                {32'h80, 5'b00100}, {32'h84, 5'b00110}};
      int lat; logic bok;
      for (int i = 0; i < 5; i++) begin
         run_op(ctrl[i], 32'h123, opb[i], 5'd0, lat, bok);
         total++;
         if (outs() !== expv[i] || lat !== 2) begin
            bad++; $display("FAIL comp_bcy_%0d got=%h lat=%0d exp=%h lat=2", i, outs(), lat, expv[i]);
         end
      end
   endtask

   task automatic test_logic();
      logic [4:0]  ctrl [3] = '{5'd2, 5'd3, 5'd3};
      logic [31:0] opa  [3] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h1234_5678};
      logic [31:0] opb  [3] = '{32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFFFF_0000};
      logic [36:0] expv [3] = '{{32'hF000_F000, 5'b00100}, {32'h0, 5'b01000}, {32'hEDCB_5678, 5'b00100}};
      int lat; logic bok;
      for (int i = 0; i < 3; i++) begin
         run_op(ctrl[i], opa[i], opb[i], 5'd0, lat, bok);
         total++;
         if (outs() !== expv[i]) begin bad++; $display("FAIL logic_%0d got=%h exp=%h", i, outs(), expv[i]); end
      end
   endtask

   task automatic test_shifts();
      logic [4:0]  ctrl [7] = '{5'd4, 5'd5, 5'd6, 5'd9, 5'd4, 5'd5, 5'd7};
      logic [31:0] opa  [7] = '{32'h1, 32'h8000_0000, 32'h3, 32'h8000_0000, 32'h8000_0001, 32'h1, 32'h8000_0000};
      logic [31:0] opb  [7] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFE0, 32'h4, 32'h0, 32'h0, 32'h1F};
      logic [4:0]  sh   [7] = '{5'd4, 5'd1, 5'd7, 5'd0, 5'd1, 5'd1, 5'd0};
      int          elat [7] = '{6, 3, 2, 6, 3, 3, 33};
      logic [36:0] expv [7] = '{{32'h10, 5'b00000}, {32'h4000_0000, 5'b00000}, {32'h3, 5'b00000},
                                {32'hF800_0000, 5'b00100}, {32'h2, 5'b00000}, {32'h0, 5'b01000},
                                {32'h1, 5'b00000}};
      int lat; logic bok;
      for (int i = 0; i < 7; i++) begin
         run_op(ctrl[i], opa[i], opb[i], sh[i], lat, bok);
         total++;
         if (outs() !== expv[i] || lat !== elat[i]) begin
            bad++; $display("FAIL shift_%0d got=%h lat=%0d exp=%h lat=%0d", i, outs(), lat, expv[i], elat[i]);
         end
      end
   endtask

   task automatic test_branches();
      logic [4:0]  ctrl [6] = '{5'd11, 5'd11, 5'd13, 5'd12, 5'd12, 5'd10};
      logic [31:0] opa  [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h2, 32'h0};
      logic        tk   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int lat; logic bok;
      for (int i = 0; i < 6; i++) begin
         run_op(ctrl[i], opa[i], 32'h100 + 32'(i * 4), 5'd3, lat, bok);
         total++;
         if (outs() !== {32'h100 + 32'(i * 4), 3'b000, tk[i], 1'b0}) begin
            bad++; $display("FAIL branch_%0d got=%h exp=%h", i, outs(), {32'h100 + 32'(i * 4), 3'b000, tk[i], 1'b0});
         end
      end
      @(negedge clk);
      total++;
      if (bus.branch_taken !== 1'b0) begin bad++; $display("FAIL branch_hold got=%b exp=0", bus.branch_taken); end
   endtask

   task automatic test_diff();
      logic [31:0] opa  [4] = '{32'h10, 32'h8000_0000, 32'h1, 32'h1234};
      logic [31:0] opb  [4] = '{32'h0, 32'h0, 32'h0, 32'h1234};
      logic [36:0] expv [4] = '{{32'd4, 5'b00000}, {32'd31, 5'b00000}, {32'd0, 5'b01000}, {32'd32, 5'b00000}};
      int lat; logic bok;
      for (int i = 0; i < 4; i++) begin
         run_op(5'd16, opa[i], opb[i], 5'd0, lat, bok);
         total++;
         if (outs() !== expv[i]) begin bad++; $display("FAIL diff_%0d got=%h exp=%h", i, outs(), expv[i]); end
      end
   endtask

   task automatic test_illegal();
      int lat; logic bok;
      run_op(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat, bok);
      total++;
      if (outs() !== {32'hFFFF_FFFE, 5'b10100}) begin bad++; $display("FAIL ill_setup got=%h exp=%h", outs(), {32'hFFFF_FFFE, 5'b10100}); end
      run_op(5'd17, 32'h5, 32'h55, 5'd2, lat, bok);
      total++;
      if (outs() !== {32'h0, 5'b10101} || lat !== 2) begin
         bad++; $display("FAIL ill_17 got=%h lat=%0d exp=%h lat=2", outs(), lat, {32'h0, 5'b10101});
      end
      @(negedge clk);
      total++;
      if ({bus.illegal, bus.branch_taken, bus.done} !== 3'b000) begin
         bad++; $display("FAIL ill_hold got=%b exp=000", {bus.illegal, bus.branch_taken, bus.done});
      end
      run_op(5'd31, 32'h0, 32'h77, 5'd0, lat, bok);
      total++;
      if (outs() !== {32'h0, 5'b10101}) begin bad++; $display("FAIL ill_31 got=%h exp=%h", outs(), {32'h0, 5'b10101}); end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2; logic bok;
      run_op(5'd2, 32'hFF, 32'h0F, 5'd0, lat1, bok);
      total++;
      if (outs() !== {32'h0F, 5'b10000} || lat1 !== 2) begin
         bad++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=2", outs(), lat1, {32'h0F, 5'b10000});
      end
      run_op(5'd3, 32'hF0, 32'h0F, 5'd0, lat2, bok);
      total++;
      if (outs() !== {32'hFF, 5'b10000} || lat2 !== 2) begin
         bad++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=2", outs(), lat2, {32'hFF, 5'b10000});
      end
   endtask

   task automatic test_reset_abort();
      logic seen;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_ctrl = 5'd6; bus.op_a = 32'h1; bus.op_b = 32'd20; bus.shamt = 5'd0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_inflight got=%b exp=1", bus.busy); end
      rst = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      total++;
      if ({outs(), bus.busy, bus.done} !== 39'h0) begin
         bad++; $display("FAIL abort_outs got=%h exp=%h", {outs(), bus.busy, bus.done}, 39'h0);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= bus.done | bus.busy;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_shra();
      test_comp_bcy();
      test_logic();
      test_shifts();
      test_branches();
      test_diff();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to execute; sampled only when busy=0.
REQ-004 SHALL have port: alu_ctrl  input  5  operation code.
- 0 add; 1 comp; 2 and; 3 xor; 4 shll; 5 shrl; 6 shllv; 7 shrlv; 8 shra; 9 shrav.
- 10 b; 11 bltz; 12 bnz; 13 bz; 14 bcy; 15 bncy; 16 diff; 17 invalid.
REQ-005 SHALL have port: op_a  input  32  first operand and shift source.
REQ-006 SHALL have port: op_b  input  32  second operand, variable shift amount in [4:0], or branch target.
REQ-007 SHALL have port: shamt  input  5  immediate shift amount for codes 4, 5 and 8.
REQ-008 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when result, branch_taken and illegal are valid.
REQ-010 SHALL have port: result  output  32  operation result, held until the next done.
REQ-011 SHALL have ports: carry_flag, zero_flag, sign_flag  output  1 each  architectural flags.
REQ-012 SHALL have ports: branch_taken, illegal  output  1 each  qualified by done.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> (SHIFT)* -> DONE -> IDLE; start in IDLE latches alu_ctrl, op_a, op_b and shamt.
REQ-014 SHALL ignore start while busy=1, with no effect on state, latched operands or outputs.
REQ-015 SHALL assert busy from the cycle after start is accepted until done, inclusive.
REQ-016 SHALL pulse done exactly 2 cycles after accept for non-shift codes, and for shifts with amount 0.
REQ-017 SHALL shift one bit per cycle for codes 4-9, so done is (2+N) cycles after accept for amount N (N=0..31).
REQ-018 SHALL compute add as op_a+op_b mod 2^32, with carry_flag taken from bit 32.
REQ-019 SHALL compute comp as (~op_b)+1, with carry_flag = carry-out (1 only when op_b=0).
REQ-020 SHALL compute and and xor bitwise; carry_flag is unchanged by these.
REQ-021 SHALL make shll/shllv logical left and shrl/shrlv logical right (zero fill), and shra/shrav arithmetic right (fill op_a[31]).
REQ-022 SHALL compute diff as the index (0..31) of the lowest bit where op_a != op_b, and 32 when they are equal.
REQ-023 SHALL update zero_flag (result==0) and sign_flag (result[31]) at done for codes 0-9 and 16.
REQ-024 SHALL evaluate branch conditions on latched values:
- b: always taken.
- bltz: op_a[31]=1; bnz: op_a!=0; bz: op_a==0.
- bcy: carry_flag=1; bncy: carry_flag=0.
REQ-025 SHALL set result=op_b for branch codes, and leave all flags unchanged.
REQ-026 SHALL treat codes 17-31 as invalid: illegal=1 and result=0 with done, branch_taken=0, flags unchanged, latency as in REQ-016.
REQ-027 SHALL hold branch_taken and illegal at 0 except in the done cycle.
REQ-028 SHALL allow back-to-back operations: start is accepted in the cycle after done.
REQ-029 SHALL make a start asserted in the same cycle as done be ignored, because busy=1 in that cycle.

Reset
REQ-030 SHALL clear all outputs, flags, latched operands and the shift counter to 0 on rst=1, and enter IDLE.
REQ-031 SHALL abort an in-flight operation on rst=1 with no done pulse; start is ignored while rst=1.

Structure
REQ-032 SHALL place alu_ctrl code constants, the data width (32) and FSM state encodings in shared package alu_pkg.
REQ-033 SHALL implement the iterative shifter as sub-module alu_shifter (load, direction/arith select, count, done).

Verification
REQ-034 SHALL cover add: op_a=0xFFFFFFFF, op_b=1 -> result=0, carry=1, zero=1, sign=0, done 2 cycles after accept.
REQ-035 SHALL cover shra: op_a=0x80000000, shamt=31 -> result=0xFFFFFFFF, sign=1, done 33 cycles after accept; start pulses mid-shift ignored.
REQ-036 SHALL cover comp op_b=0 (carry=1), followed by bcy op_b=0x40 -> branch_taken=1, result=0x40, flags unchanged.
REQ-037 SHALL cover diff: op_a=0x10, op_b=0x00 -> result=4; op_a=op_b=0x1234 -> result=32, zero=0.
REQ-038 SHALL cover alu_ctrl=17 -> illegal=1, result=0, flags unchanged; then rst during a shllv with op_b=20 -> all outputs 0 and no done pulse.
